label_stripper: RTL and testbench
=================================

# label_stripper

Receive-side inverse of the packet labeler: consumes an AXI-Stream whose first beat of every packet is a label, removes that beat, and presents the remaining payload beats with the label on a sideband `out_tid` held for the whole packet. It sits where labeled streams are split back out, feeding per-ID consumers or demultiplexers. It is fully pipelined: one registered output stage, and label beats are absorbed without stalling the output.

## Interface
- `DATA_WIDTH`, default 8: width of `in_tdata`, `out_tdata`, `out_tid` and the captured label.
- `aclk`  in  1  sole clock; all logic on rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `in_tvalid`  in  1  upstream beat valid.
- `in_tready`  out  1  upstream beat accepted when high with `in_tvalid`.
- `in_tdata`  in  DATA_WIDTH  label (first beat) or payload.
- `in_tlast`  in  1  last beat of the labeled packet.
- `out_tvalid`  out  1  payload beat valid.
- `out_tready`  in  1  downstream ready.
- `out_tdata`  out  DATA_WIDTH  payload beat.
- `out_tlast`  out  1  last payload beat of the packet.
- `out_tid`  out  DATA_WIDTH  label of the packet this beat belongs to.
- `pkt_count`  out  16  delivered packets (only with `LABEL_STRIPPER_STATS_EN`).
- `runt_count`  out  16  label-only packets dropped (only with `LABEL_STRIPPER_STATS_EN`).

## Operation
- Two-state FSM: LABEL (expecting label beat) and BODY (forwarding payload). Reset state is LABEL.
- In LABEL, an accepted beat with `in_tlast=0` is captured into the label register and the FSM moves to BODY. Nothing goes to the output.
- In LABEL, an accepted beat with `in_tlast=1` is a runt. It is discarded, the FSM stays in LABEL, and `runt_count` increments.
- In BODY, each accepted beat loads the output register: `out_tdata<=in_tdata`, `out_tlast<=in_tlast`, `out_tid<=label register`, `out_tvalid<=1`. If `in_tlast=1`, the FSM goes to LABEL.
- `out_tid` is registered per beat. Capturing the next label never disturbs a beat still held at the output.
- Output register: it clears `out_tvalid` on `out_tready` unless it is reloaded in the same cycle. While `out_tvalid && !out_tready`, `out_tdata`, `out_tlast` and `out_tid` are stable.
- `in_tready = (state==LABEL) || !out_tvalid || out_tready`. This is combinational from `out_tready`.
- No payload beat is dropped, duplicated or reordered. An empty-payload packet produces no output.

## Timing
- Reset values: `out_tvalid=0`, `out_tlast=0`, `out_tdata=0`, `out_tid=0`, label register 0, state LABEL, counters 0.
- Latency: a payload beat accepted in cycle N is presented with `out_tvalid=1` in cycle N+1.
- Throughput: 1 payload beat/cycle with `out_tready` held high. The label beat costs one input cycle and creates one output bubble between packets.
- Label accepted in the same cycle that the previous packet's last beat is held: allowed. The held beat keeps its old `out_tid`.
- Back-pressure: `out_tready=0` with `out_tvalid=1` in BODY forces `in_tready=0`.
- Reset mid-packet drops any held output beat and any partial packet state. The first beat accepted after reset is treated as a label.

## Configuration
- `LABEL_STRIPPER_STATS_EN` defined:
  - `pkt_count` and `runt_count` ports and 16-bit counters exist.
  - `pkt_count` increments on each output handshake with `out_tlast=1`.
  - `runt_count` increments on each runt accepted.
  - Both wrap 0xFFFF→0 and clear only on reset.
- Not defined: the ports and logic are absent. Datapath behaviour is identical either way.

## Structure
- Shared package: FSM state typedef (LABEL, BODY) and `LABEL_STRIPPER_CNT_W = 16`.
- No sub-module: the FSM, label register and single output register are small enough to live in one module.

## Test plan
- Labeled packet label 0x5A, then 0x11, 0x22, 0x33 (last), with `out_tready=1` → output 0x11, 0x22, 0x33, `out_tid=0x5A` on all three, `out_tlast` on 0x33 only. First output appears 1 cycle after 0x11 is accepted.
- Back-to-back packets (0x01: 0xA0, 0xA1 last), (0x02: 0xB0 last) → 0xA0/0x01, 0xA1/0x01/last, 0xB0/0x02/last. Exactly one bubble between the packets.
- Runt: label 0x7F with `in_tlast=1`, then packet (0x03: 0xC0 last) → only 0xC0 with `out_tid=0x03` is output. With STATS: `runt_count=1`, `pkt_count=1`.
- Stall: `out_tready=0` for 5 cycles while 0x22 is held → `out_tdata`, `out_tid` and `out_tlast` stay stable and `in_tready=0`. After release, no beat is lost.
- Hold plus label overlap: last beat 0x33 (id 0x5A) stalled while next label 0x66 arrives → `in_tready=1` and the label is accepted. `out_tid` stays 0x5A until 0x33 is handshaken, and the next beat carries 0x66.
- Reset asserted mid-packet after 0x11 → `out_tvalid=0` next cycle. The first post-reset beat 0x09 is treated as a label and not output.

Source files
------------

// File: rtl/label_stripper_pkg.sv
// Shared types for label_stripper: FSM state encoding and statistics counter width.
package label_stripper_pkg;

    typedef enum logic {
        ST_LABEL = 1'b0,
        ST_BODY  = 1'b1
    } state_t;

    localparam int LABEL_STRIPPER_CNT_W = 16;

endpackage

// File: rtl/label_stripper.sv
// Strips the leading label beat of each AXI-Stream packet and presents it on out_tid.
// Optional statistics counters are built only when LABEL_STRIPPER_STATS_EN is defined.
module label_stripper
    import label_stripper_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            in_tvalid,
    output logic                            in_tready,
    input  logic [DATA_WIDTH-1:0]           in_tdata,
    input  logic                            in_tlast,
    output logic                            out_tvalid,
    input  logic                            out_tready,
    output logic [DATA_WIDTH-1:0]           out_tdata,
    output logic                            out_tlast,
    output logic [DATA_WIDTH-1:0]           out_tid,
`ifdef LABEL_STRIPPER_STATS_EN
    output logic [LABEL_STRIPPER_CNT_W-1:0] pkt_count,
    output logic [LABEL_STRIPPER_CNT_W-1:0] runt_count,
`endif
    output state_t                          o_dbg_state
);

    // Handshake rule on both ports: a beat transfers on a rising edge where
    // valid and ready are both high; a producer holds valid and its payload
    // stable until that edge, and ready may depend combinationally on valid.

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_WIDTH-1:0]   r_label;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_last;
    logic [DATA_WIDTH-1:0]   r_out_tid;
    logic                    w_in_hs;
    logic                    w_load;
    logic                    w_capture;
    logic                    w_runt;

    // A label beat never touches the output register, so it is always accepted.
    assign in_tready = (r_state == ST_LABEL) || !r_out_valid || out_tready;
    assign w_in_hs   = in_tvalid && in_tready;

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_runt       = 1'b0;
        case (r_state)
            ST_LABEL: begin
                if (w_in_hs) begin
                    if (in_tlast) begin
                        w_runt = 1'b1;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (w_in_hs) begin
                    w_load = 1'b1;
                    if (in_tlast) begin
                        w_next_state = ST_LABEL;
                    end
                end
            end
            default: w_next_state = ST_LABEL;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_LABEL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_label     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_tid   <= '0;
        end else begin
            if (w_capture) begin
                r_label <= in_tdata;
            end
            // out_tid is taken per beat, so a new label cannot alter a held beat.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_tdata;
                r_out_last  <= in_tlast;
                r_out_tid   <= r_label;
            end else if (out_tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_tvalid  = r_out_valid;
    assign out_tdata   = r_out_data;
    assign out_tlast   = r_out_last;
    assign out_tid     = r_out_tid;
    assign o_dbg_state = r_state;

`ifdef LABEL_STRIPPER_STATS_EN
    logic [LABEL_STRIPPER_CNT_W-1:0] r_pkt_count;
    logic [LABEL_STRIPPER_CNT_W-1:0] r_runt_count;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_pkt_count  <= '0;
            r_runt_count <= '0;
        end else begin
            if (r_out_valid && out_tready && r_out_last) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end
            if (w_runt) begin
                r_runt_count <= r_runt_count + 1'b1;
            end
        end
    end

    assign pkt_count  = r_pkt_count;
    assign runt_count = r_runt_count;
`endif

endmodule

// File: tb/tb_label_stripper.sv
// Self-checking bench for label_stripper: directed scenarios plus a randomized
// packet stream compared against a packet-level reference model.
module tb_label_stripper;
  import label_stripper_pkg::*;

  localparam int W = 8;

  logic         aclk;
  logic         areset;
  logic         in_tvalid;
  logic         in_tready;
  logic [W-1:0] in_tdata;
  logic         in_tlast;
  logic         out_tvalid;
  logic         out_tready;
  logic [W-1:0] out_tdata;
  logic         out_tlast;
  logic [W-1:0] out_tid;
  state_t       dbg_state;
`ifdef LABEL_STRIPPER_STATS_EN
  logic [15:0]  pkt_count;
  logic [15:0]  runt_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // expected output beats packed as {tid, last, data}
  logic [2*W:0] exp_q[$];
  logic [W:0]   in_q[$];   // input beats as {last, data}

  label_stripper #(.DATA_WIDTH(W)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tdata   (in_tdata),
    .in_tlast   (in_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .out_tlast  (out_tlast),
    .out_tid    (out_tid),
`ifdef LABEL_STRIPPER_STATS_EN
    .pkt_count  (pkt_count),
    .runt_count (runt_count),
`endif
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1; in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0; out_tready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge; outputs are then sampled
  // #1 later, before the next rising edge consumes them.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic l, input logic rdy);
    @(negedge aclk);
    in_tvalid = v; in_tdata = d; in_tlast = l; out_tready = rdy;
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [W-1:0] tid, input logic last,
                             input logic [W-1:0] data);
    check_eq({tag, ".valid"}, {31'd0, out_tvalid}, 32'd1);
    check_eq({tag, ".beat"}, {15'd0, out_tid, out_tlast, out_tdata}, {15'd0, tid, last, data});
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, ".valid"}, {31'd0, out_tvalid}, 32'd0);
  endtask

  task automatic run_random();
    int n_pkts = 40;
    int exp_pkts = 0;
    int exp_runts = 0;
    int cycles = 0;
    logic         prev_hold = 1'b0;
    logic [2*W:0] prev_beat = '0;
    logic [2*W:0] got_beat;
    logic [2*W:0] exp_beat;
    logic [W-1:0] lbl;
    int           len;
    bit           done = 0;
    logic [W:0]   cur;

    for (int p = 0; p < n_pkts; p++) begin
      lbl = W'($urandom_range(0, 255));
      len = $urandom_range(0, 5);
      in_q.push_back({(len == 0), lbl});
      if (len == 0) exp_runts++;
      else exp_pkts++;
      for (int b = 0; b < len; b++) begin
        logic [W-1:0] d;
        d = W'($urandom_range(0, 255));
        in_q.push_back({(b == len - 1), d});
        exp_q.push_back({lbl, (b == len - 1), d});
      end
    end

    while (!done && cycles < 5000) begin
      cur = (in_q.size() > 0) ? in_q[0] : '0;
      drive((in_q.size() > 0) && ($urandom_range(0, 3) != 0), cur[W-1:0], cur[W],
            $urandom_range(0, 3) != 0);
      cycles++;
      got_beat = {out_tid, out_tlast, out_tdata};
      if (prev_hold) begin
        check_eq("rand.hold_valid", {31'd0, out_tvalid}, 32'd1);
        check_eq("rand.hold_stable", {15'd0, got_beat}, {15'd0, prev_beat});
      end
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("rand.extra_beat", {15'd0, got_beat}, 32'hFFFF_FFFF);
        end else begin
          exp_beat = exp_q.pop_front();
          check_eq("rand.beat", {15'd0, got_beat}, {15'd0, exp_beat});
        end
      end
      prev_hold = out_tvalid && !out_tready;
      prev_beat = got_beat;
      if (in_tvalid && in_tready) void'(in_q.pop_front());
      done = (in_q.size() == 0) && (exp_q.size() == 0) && !(out_tvalid && !out_tready);
    end
    check_eq("rand.completed", {31'd0, done}, 32'd1);
    check_eq("rand.leftover_out", exp_q.size(), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1);
`ifdef LABEL_STRIPPER_STATS_EN
    check_eq("rand.pkt_count", {16'd0, pkt_count}, exp_pkts);
    check_eq("rand.runt_count", {16'd0, runt_count}, exp_runts);
`else
    if (exp_pkts + exp_runts != n_pkts) check_eq("rand.pkt_total", exp_pkts + exp_runts, n_pkts);
`endif
  endtask

  initial begin
    areset = 1'b1; in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0; out_tready = 1'b0;

    // reset state
    do_reset();
    #1;
    check_eq("rst.out_tvalid", {31'd0, out_tvalid}, 32'd0);
    check_eq("rst.out_beat", {15'd0, out_tid, out_tlast, out_tdata}, 32'd0);
    check_eq("rst.in_tready", {31'd0, in_tready}, 32'd1);
`ifdef LABEL_STRIPPER_STATS_EN
    check_eq("rst.pkt_count", {16'd0, pkt_count}, 32'd0);
    check_eq("rst.runt_count", {16'd0, runt_count}, 32'd0);
`endif

    // single labeled packet, one-cycle latency
    drive(1, 8'h5A, 0, 1); expect_idle("p1.label");
    drive(1, 8'h11, 0, 1); expect_idle("p1.c0");
    drive(1, 8'h22, 0, 1); expect_beat("p1.b0", 8'h5A, 0, 8'h11);
    drive(1, 8'h33, 1, 1); expect_beat("p1.b1", 8'h5A, 0, 8'h22);
    drive(0, 8'h00, 0, 1); expect_beat("p1.b2", 8'h5A, 1, 8'h33);
    drive(0, 8'h00, 0, 1); expect_idle("p1.end");

    // back-to-back packets with one bubble
    do_reset();
    drive(1, 8'h01, 0, 1); expect_idle("b2b.l0");
    drive(1, 8'hA0, 0, 1); expect_idle("b2b.c0");
    drive(1, 8'hA1, 1, 1); expect_beat("b2b.a0", 8'h01, 0, 8'hA0);
    drive(1, 8'h02, 0, 1); expect_beat("b2b.a1", 8'h01, 1, 8'hA1);
    drive(1, 8'hB0, 1, 1); expect_idle("b2b.bubble");
    drive(0, 8'h00, 0, 1); expect_beat("b2b.b0", 8'h02, 1, 8'hB0);
    drive(0, 8'h00, 0, 1); expect_idle("b2b.end");

    // runt dropped
    do_reset();
    drive(1, 8'h7F, 1, 1); expect_idle("runt.r");
    drive(1, 8'h03, 0, 1); expect_idle("runt.l");
    drive(1, 8'hC0, 1, 1); expect_idle("runt.c");
    drive(0, 8'h00, 0, 1); expect_beat("runt.c0", 8'h03, 1, 8'hC0);
    drive(0, 8'h00, 0, 1); expect_idle("runt.end");
`ifdef LABEL_STRIPPER_STATS_EN
    check_eq("runt.runt_count", {16'd0, runt_count}, 32'd1);
    check_eq("runt.pkt_count", {16'd0, pkt_count}, 32'd1);
`endif

    // stall while 0x22 is held
    do_reset();
    drive(1, 8'h5A, 0, 1);
    drive(1, 8'h11, 0, 1);
    drive(1, 8'h22, 0, 1); expect_beat("stall.b0", 8'h5A, 0, 8'h11);
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h33, 1, 0);
      expect_beat("stall.held", 8'h5A, 0, 8'h22);
      check_eq("stall.in_tready", {31'd0, in_tready}, 32'd0);
    end
    drive(1, 8'h33, 1, 1); expect_beat("stall.rel", 8'h5A, 0, 8'h22);
    check_eq("stall.rel_in_tready", {31'd0, in_tready}, 32'd1);
    drive(0, 8'h00, 0, 1); expect_beat("stall.b2", 8'h5A, 1, 8'h33);
    drive(0, 8'h00, 0, 1); expect_idle("stall.end");

    // next label accepted while previous last beat is held
    do_reset();
    drive(1, 8'h5A, 0, 1);
    drive(1, 8'h33, 1, 1); expect_idle("ovl.c");
    drive(1, 8'h66, 0, 0); expect_beat("ovl.held", 8'h5A, 1, 8'h33);
    check_eq("ovl.label_ready", {31'd0, in_tready}, 32'd1);
    drive(1, 8'h77, 1, 0); expect_beat("ovl.held2", 8'h5A, 1, 8'h33);
    check_eq("ovl.body_stall", {31'd0, in_tready}, 32'd0);
    drive(1, 8'h77, 1, 1); expect_beat("ovl.rel", 8'h5A, 1, 8'h33);
    drive(0, 8'h00, 0, 1); expect_beat("ovl.next", 8'h66, 1, 8'h77);
    drive(0, 8'h00, 0, 1); expect_idle("ovl.end");

    // reset mid-packet
    do_reset();
    drive(1, 8'h5A, 0, 1);
    drive(1, 8'h11, 0, 1);
    drive(0, 8'h00, 0, 0); expect_beat("mrst.held", 8'h5A, 0, 8'h11);
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    #1;
    expect_idle("mrst.cleared");
    drive(1, 8'h09, 0, 1); expect_idle("mrst.l");
    drive(1, 8'h44, 1, 1); expect_idle("mrst.c");
    drive(0, 8'h00, 0, 1); expect_beat("mrst.b0", 8'h09, 1, 8'h44);

    // randomized stream against packet-level model
    do_reset();
    run_random();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
